rob_commit_unit: RTL and testbench

//  Reorder buffer sitting directly downstream of the middle end. Allocates one entry per dispatched op,

---
 rtl/rob_commit_unit.sv | 198 +++++++++++++++++++
 tb/tb_rob_commit_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// In-order commit buffer: allocates one entry per dispatched op, marks completions by index,
// retires from the head one op per cycle, and unwinds younger entries after a failed terminator.
module rob_commit_unit #(
    parameter int DEPTH     = 32,
    parameter int IDX_W     = 5,
    parameter int PR_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [1:0]             alloc_dest_mask,
    input  logic [7:0]             alloc_arch_dests,
    input  logic [2*PR_ADDR_W-1:0] alloc_phys_dests,
    input  logic [2*PR_ADDR_W-1:0] alloc_old_phys,
    output logic [IDX_W-1:0]       alloc_entry,
    input  logic                   complete_arith_valid,
    input  logic                   complete_mem_valid,
    input  logic                   complete_term_valid,
    output logic                   complete_term_ready,
    input  logic                   complete_term_failed,
    input  logic [15:0]            term_address,
    input  logic [3*IDX_W-1:0]     ROB_entries_in,
    output logic                   retire_valid,
    output logic [1:0]             retire_dest_mask,
    output logic [7:0]             retire_arch_dests,
    output logic [2*PR_ADDR_W-1:0] retire_phys_dests,
    output logic [1:0]             free_valid,
    output logic [2*PR_ADDR_W-1:0] free_phys,
    output logic [1:0]             rollback_valid,
    output logic [7:0]             rollback_arch,
    output logic [2*PR_ADDR_W-1:0] rollback_phys,
    output logic                   flush,
    output logic [15:0]            redirect_pc,
    output logic [1:0]             debug_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SQUASH   = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] head_q, tail_q, walk_q;
    logic [IDX_W:0]   count_q;
    logic [15:0]      redirect_addr_q;
    logic [DEPTH-1:0] busy_q, done_q, failed_q;

    logic [1:0]             mask_mem [DEPTH];
    logic [7:0]             arch_mem [DEPTH];
    logic [2*PR_ADDR_W-1:0] phys_mem [DEPTH];
    logic [2*PR_ADDR_W-1:0] old_mem  [DEPTH];
    logic [15:0]            addr_mem [DEPTH];

    logic             in_run, alloc_fire, pop, pop_failed;
    logic             arith_fire, mem_fire, term_fire;
    logic [IDX_W-1:0] arith_idx, mem_idx, term_idx;

    assign arith_idx = ROB_entries_in[3*IDX_W-1:2*IDX_W];
    assign mem_idx   = ROB_entries_in[2*IDX_W-1:IDX_W];
    assign term_idx  = ROB_entries_in[IDX_W-1:0];

    assign in_run              = (state_q == RUN);
    assign alloc_ready         = in_run && (count_q < (IDX_W+1)'(DEPTH));
    assign alloc_entry         = tail_q;
    assign complete_term_ready = in_run;
    assign debug_state         = state_q;

    assign alloc_fire = alloc_valid && alloc_ready;
    // Completions aimed at entries that are not in flight are silently dropped.
    assign arith_fire = in_run && complete_arith_valid && busy_q[arith_idx];
    assign mem_fire   = in_run && complete_mem_valid && busy_q[mem_idx];
    assign term_fire  = in_run && complete_term_valid && busy_q[term_idx];

    assign pop        = in_run && busy_q[head_q] && done_q[head_q];
    assign pop_failed = pop && failed_q[head_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (pop_failed) begin
                    state_d = (count_q == (IDX_W+1)'(1)) ? REDIRECT : SQUASH;
                end
            end
            SQUASH: begin
                if (walk_q == head_q) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Payload storage needs no reset: busy gates every read that matters.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            mask_mem[tail_q] <= alloc_dest_mask;
            arch_mem[tail_q] <= alloc_arch_dests;
            phys_mem[tail_q] <= alloc_phys_dests;
            old_mem[tail_q]  <= alloc_old_phys;
        end
        if (term_fire) begin
            addr_mem[term_idx] <= term_address;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= RUN;
            head_q            <= '0;
            tail_q            <= '0;
            walk_q            <= '0;
            count_q           <= '0;
            redirect_addr_q   <= '0;
            busy_q            <= '0;
            done_q            <= '0;
            failed_q          <= '0;
            retire_valid      <= 1'b0;
            retire_dest_mask  <= '0;
            retire_arch_dests <= '0;
            retire_phys_dests <= '0;
            free_valid        <= '0;
            free_phys         <= '0;
            rollback_valid    <= '0;
            rollback_arch     <= '0;
            rollback_phys     <= '0;
            flush             <= 1'b0;
            redirect_pc       <= '0;
        end else begin
            state_q           <= state_d;
            retire_valid      <= 1'b0;
            retire_dest_mask  <= '0;
            retire_arch_dests <= '0;
            retire_phys_dests <= '0;
            free_valid        <= '0;
            free_phys         <= '0;
            rollback_valid    <= '0;
            rollback_arch     <= '0;
            rollback_phys     <= '0;
            flush             <= 1'b0;
            redirect_pc       <= '0;
            case (state_q)
                RUN: begin
                    if (alloc_fire) begin
                        busy_q[tail_q]   <= 1'b1;
                        done_q[tail_q]   <= 1'b0;
                        failed_q[tail_q] <= 1'b0;
                        tail_q           <= tail_q + IDX_W'(1);
                    end
                    if (arith_fire) done_q[arith_idx] <= 1'b1;
                    if (mem_fire)   done_q[mem_idx]   <= 1'b1;
                    if (term_fire) begin
                        done_q[term_idx]   <= 1'b1;
                        failed_q[term_idx] <= complete_term_failed;
                    end
                    if (pop) begin
                        busy_q[head_q]    <= 1'b0;
                        retire_valid      <= 1'b1;
                        retire_dest_mask  <= mask_mem[head_q];
                        retire_arch_dests <= arch_mem[head_q];
                        retire_phys_dests <= phys_mem[head_q];
                        free_valid        <= mask_mem[head_q];
                        free_phys         <= old_mem[head_q];
                        head_q            <= head_q + IDX_W'(1);
                        if (pop_failed) begin
                            redirect_addr_q <= addr_mem[head_q];
                            walk_q          <= tail_q - IDX_W'(1);
                        end
                    end
                    count_q <= count_q + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, pop};
                end
                SQUASH: begin
                    // Youngest first, so the rename table unwinds in reverse program order.
                    busy_q[walk_q] <= 1'b0;
                    rollback_valid <= mask_mem[walk_q];
                    rollback_arch  <= arch_mem[walk_q];
                    rollback_phys  <= old_mem[walk_q];
                    free_valid     <= mask_mem[walk_q];
                    free_phys      <= phys_mem[walk_q];
                    walk_q         <= walk_q - IDX_W'(1);
                end
                REDIRECT: begin
                    flush       <= 1'b1;
                    redirect_pc <= redirect_addr_q;
                    tail_q      <= head_q;
                    count_q     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: a vector table for in-order retire plus hand sequences
// for full, wrap, squash, lone-failed-terminator and mid-squash reset.
module tb_rob_commit_unit;
    localparam int DEPTH = 32;
    localparam int IDX_W = 5;
    localparam int PR_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [1:0]        alloc_dest_mask;
    logic [7:0]        alloc_arch_dests;
    logic [2*PR_W-1:0] alloc_phys_dests;
    logic [2*PR_W-1:0] alloc_old_phys;
    logic [IDX_W-1:0]  alloc_entry;
    logic              complete_arith_valid;
    logic              complete_mem_valid;
    logic              complete_term_valid;
    logic              complete_term_ready;
    logic              complete_term_failed;
    logic [15:0]       term_address;
    logic [3*IDX_W-1:0] ROB_entries_in;
    logic              retire_valid;
    logic [1:0]        retire_dest_mask;
    logic [7:0]        retire_arch_dests;
    logic [2*PR_W-1:0] retire_phys_dests;
    logic [1:0]        free_valid;
    logic [2*PR_W-1:0] free_phys;
    logic [1:0]        rollback_valid;
    logic [7:0]        rollback_arch;
    logic [2*PR_W-1:0] rollback_phys;
    logic              flush;
    logic [15:0]       redirect_pc;
    logic [1:0]        debug_state;

    rob_commit_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PR_ADDR_W(PR_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_dest_mask(alloc_dest_mask), .alloc_arch_dests(alloc_arch_dests),
        .alloc_phys_dests(alloc_phys_dests), .alloc_old_phys(alloc_old_phys),
        .alloc_entry(alloc_entry),
        .complete_arith_valid(complete_arith_valid), .complete_mem_valid(complete_mem_valid),
        .complete_term_valid(complete_term_valid), .complete_term_ready(complete_term_ready),
        .complete_term_failed(complete_term_failed), .term_address(term_address),
        .ROB_entries_in(ROB_entries_in),
        .retire_valid(retire_valid), .retire_dest_mask(retire_dest_mask),
        .retire_arch_dests(retire_arch_dests), .retire_phys_dests(retire_phys_dests),
        .free_valid(free_valid), .free_phys(free_phys),
        .rollback_valid(rollback_valid), .rollback_arch(rollback_arch),
        .rollback_phys(rollback_phys),
        .flush(flush), .redirect_pc(redirect_pc), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int ret_cyc = 0;
    int flush_cyc = 0;
    int flush_cnt = 0;
    int nretired = 0;
    bit watch = 1'b0;
    logic [7:0] term_arch;
    logic [7:0] exp_q[$];
    logic [31:0] ev_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Op i carries arch dests = i, slot0 phys = i+16, slot0 old phys = i.
    function automatic logic [1:0] op_mask(input logic [7:0] i);
        return (i[2:0] == 3'd6) ? 2'b11 : 2'b01;
    endfunction
    function automatic logic [4:0] p0(input logic [7:0] i);
        return i[4:0] + 5'd16;
    endfunction
    function automatic logic [4:0] o0(input logic [7:0] i);
        return i[4:0];
    endfunction
    function automatic logic [31:0] mk_ev(input logic [3:0] t, input logic [1:0] m, input logic [1:0] fv,
                                          input logic [7:0] a, input logic [4:0] pa, input logic [4:0] pb);
        return {t, 6'h0, m, fv, a, pa, pb};
    endfunction
    function automatic logic [31:0] ev_retire(input logic [7:0] i);
        return mk_ev(4'h1, op_mask(i), op_mask(i), i, p0(i), o0(i));
    endfunction
    function automatic logic [31:0] ev_rollback(input logic [7:0] i);
        return mk_ev(4'h2, op_mask(i), op_mask(i), i, o0(i), p0(i));
    endfunction

    task automatic clear_inputs();
        alloc_valid = 1'b0; alloc_dest_mask = '0; alloc_arch_dests = '0;
        alloc_phys_dests = '0; alloc_old_phys = '0;
        complete_arith_valid = 1'b0; complete_mem_valid = 1'b0;
        complete_term_valid = 1'b0; complete_term_failed = 1'b0;
        term_address = '0; ROB_entries_in = '0;
    endtask

    task automatic drive_alloc(input logic [7:0] i);
        alloc_valid      = 1'b1;
        alloc_dest_mask  = op_mask(i);
        alloc_arch_dests = i;
        alloc_phys_dests = {~i[4:0], p0(i)};
        alloc_old_phys   = {5'h1F, o0(i)};
    endtask

    task automatic got(input string name, input logic [31:0] act);
        if (ev_q.size() == 0) begin
            checks++;
            $display("FAIL %s: unexpected event %h", name, act);
        end else begin
            chk(name, act, ev_q.pop_front());
        end
    endtask

    task automatic observe();
        if (retire_valid) begin
            got("retire_event", mk_ev(4'h1, retire_dest_mask, free_valid, retire_arch_dests,
                                      retire_phys_dests[4:0], free_phys[4:0]));
            if (retire_arch_dests == term_arch) begin
                ret_cyc = cyc;
                chk("ready_after_failed_retire", 32'(alloc_ready), 32'd0);
            end
        end
        if (rollback_valid != 2'b00) begin
            got("rollback_event", mk_ev(4'h2, rollback_valid, free_valid, rollback_arch,
                                        rollback_phys[4:0], free_phys[4:0]));
            chk("ready_in_squash", 32'(alloc_ready), 32'd0);
        end
        if (flush) begin
            got("flush_event", {4'h3, 12'h0, redirect_pc});
            flush_cyc = cyc;
            flush_cnt++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (watch) observe();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_retire_valid"}, 32'(retire_valid), 32'd0);
        chk({tag, "_retire_arch"}, 32'(retire_arch_dests), 32'd0);
        chk({tag, "_free_valid"}, 32'(free_valid), 32'd0);
        chk({tag, "_rollback_valid"}, 32'(rollback_valid), 32'd0);
        chk({tag, "_flush"}, 32'(flush), 32'd0);
        chk({tag, "_redirect_pc"}, 32'(redirect_pc), 32'd0);
        chk({tag, "_alloc_ready"}, 32'(alloc_ready), 32'd1);
        chk({tag, "_term_ready"}, 32'(complete_term_ready), 32'd1);
        chk({tag, "_alloc_entry"}, 32'(alloc_entry), 32'd0);
    endtask

    typedef struct {
        logic       av;
        logic [7:0] aop;
        logic       cav;
        logic [4:0] cai;
        logic       cmv;
        logic [4:0] cmi;
        logic       ctv;
        logic [4:0] cti;
        logic       exp_ready;
        logic [4:0] exp_entry;
        logic       exp_rv;
        logic [7:0] exp_rarch;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Alloc 0,1,2 then complete 2,0,1: retire must still come out 0,1,2.
        vecs[0] = '{1'b1, 8'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 8'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 8'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 8'd0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 8'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd3, 1'b0, 8'd0};
        vecs[6] = '{1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 8'd0};
        vecs[7] = '{1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 8'd1};
        vecs[8] = '{1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 8'd2};
        vecs[9] = '{1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 8'd0};

        term_arch = 8'hFF;
        rst = 1'b0;
        clear_inputs();
        #1;
        check_idle_outputs("reset");
        reset_dut();

        // ---- table: out-of-order completion, in-order retire
        for (int r = 0; r < 10; r++) begin
            tick();
            chk($sformatf("v%0d_ready", r), 32'(alloc_ready), 32'(vecs[r].exp_ready));
            chk($sformatf("v%0d_entry", r), 32'(alloc_entry), 32'(vecs[r].exp_entry));
            chk($sformatf("v%0d_retire_valid", r), 32'(retire_valid), 32'(vecs[r].exp_rv));
            chk($sformatf("v%0d_retire_arch", r), 32'(retire_arch_dests), 32'(vecs[r].exp_rarch));
            chk($sformatf("v%0d_free_valid", r), 32'(free_valid),
                vecs[r].exp_rv ? 32'(op_mask(vecs[r].exp_rarch)) : 32'd0);
            if (vecs[r].exp_rv)
                chk($sformatf("v%0d_free_phys", r), 32'(free_phys[4:0]), 32'(o0(vecs[r].exp_rarch)));
            clear_inputs();
            if (vecs[r].av) drive_alloc(vecs[r].aop);
            complete_arith_valid = vecs[r].cav;
            complete_mem_valid   = vecs[r].cmv;
            complete_term_valid  = vecs[r].ctv;
            ROB_entries_in       = {vecs[r].cai, vecs[r].cmi, vecs[r].cti};
        end

        // ---- full buffer: alloc refused at 32, and still refused on a same-cycle retire
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (alloc_entry != 5'(i) || !alloc_ready)
                chk($sformatf("fill_%0d", i), {27'(alloc_ready), alloc_entry}, {27'd1, 5'(i)});
            else
                chk("fill_entry", 32'(alloc_entry), 32'(i));
            clear_inputs();
            drive_alloc(8'(i));
        end
        tick();
        chk("full_ready", 32'(alloc_ready), 32'd0);
        chk("full_entry", 32'(alloc_entry), 32'd0);
        clear_inputs();
        complete_arith_valid = 1'b1;
        ROB_entries_in = {5'd0, 5'd0, 5'd0};
        tick();
        chk("full_ready_during_pop", 32'(alloc_ready), 32'd0);
        clear_inputs();
        drive_alloc(8'd99);
        tick();
        chk("full_pop_retire_valid", 32'(retire_valid), 32'd1);
        chk("full_pop_retire_arch", 32'(retire_arch_dests), 32'd0);
        chk("full_after_pop_ready", 32'(alloc_ready), 32'd1);
        chk("full_refused_entry", 32'(alloc_entry), 32'd0);
        clear_inputs();

        // ---- tail wrap with steady retire, scoreboard on arch dests
        reset_dut();
        exp_q.delete();
        nretired = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            clear_inputs();
            if (i < 40) begin
                chk($sformatf("wrap_entry_%0d", i), 32'(alloc_entry), 32'(i % DEPTH));
                drive_alloc(8'(i));
                exp_q.push_back(8'(i));
            end
            if (i >= 1 && i <= 40) begin
                complete_arith_valid = 1'b1;
                ROB_entries_in = {5'((i - 1) % DEPTH), 5'd0, 5'd0};
            end
            if (retire_valid) begin
                nretired++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL wrap_retire: unexpected retire arch %h", retire_arch_dests);
                end else begin
                    chk("wrap_retire_order", 32'(retire_arch_dests), 32'(exp_q.pop_front()));
                end
            end
        end
        chk("wrap_retire_count", 32'(nretired), 32'd40);
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---- failed terminator at idx 4 with three younger ops
        reset_dut();
        ev_q.delete();
        flush_cnt = 0;
        term_arch = 8'd4;
        for (int i = 0; i < 5; i++) ev_q.push_back(ev_retire(8'(i)));
        ev_q.push_back(ev_rollback(8'd7));
        ev_q.push_back(ev_rollback(8'd6));
        ev_q.push_back(ev_rollback(8'd5));
        ev_q.push_back({4'h3, 12'h0, 16'h1234});
        watch = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            clear_inputs();
            drive_alloc(8'(i));
        end
        tick();
        clear_inputs();
        complete_arith_valid = 1'b1; complete_mem_valid = 1'b1; complete_term_valid = 1'b1;
        ROB_entries_in = {5'd0, 5'd1, 5'd2};
        tick();
        clear_inputs();
        complete_arith_valid = 1'b1; complete_term_valid = 1'b1; complete_term_failed = 1'b1;
        term_address = 16'h1234;
        ROB_entries_in = {5'd3, 5'd0, 5'd4};
        tick();
        clear_inputs();
        for (int k = 0; k < 40 && flush_cnt == 0; k++) tick();
        tick();
        chk("squash_flush_count", 32'(flush_cnt), 32'd1);
        chk("squash_flush_latency", 32'(flush_cyc - ret_cyc), 32'd4);
        chk("squash_events_left", 32'(ev_q.size()), 32'd0);
        chk("squash_ready_after", 32'(alloc_ready), 32'd1);
        chk("squash_entry_after", 32'(alloc_entry), 32'd5);
        watch = 1'b0;

        // ---- failed terminator as the only entry: no rollback, flush next cycle
        reset_dut();
        ev_q.delete();
        flush_cnt = 0;
        term_arch = 8'd0;
        ev_q.push_back(ev_retire(8'd0));
        ev_q.push_back({4'h3, 12'h0, 16'hBEEF});
        watch = 1'b1;
        tick();
        drive_alloc(8'd0);
        tick();
        clear_inputs();
        complete_term_valid = 1'b1; complete_term_failed = 1'b1;
        term_address = 16'hBEEF;
        ROB_entries_in = {5'd0, 5'd0, 5'd0};
        tick();
        clear_inputs();
        for (int k = 0; k < 20 && flush_cnt == 0; k++) tick();
        tick();
        chk("lone_flush_count", 32'(flush_cnt), 32'd1);
        chk("lone_flush_latency", 32'(flush_cyc - ret_cyc), 32'd1);
        chk("lone_events_left", 32'(ev_q.size()), 32'd0);
        chk("lone_ready_after", 32'(alloc_ready), 32'd1);
        chk("lone_entry_after", 32'(alloc_entry), 32'd1);
        watch = 1'b0;

        // ---- asynchronous reset in the middle of a squash
        reset_dut();
        term_arch = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            tick();
            clear_inputs();
            drive_alloc(8'(i));
        end
        tick();
        clear_inputs();
        complete_term_valid = 1'b1; complete_term_failed = 1'b1;
        term_address = 16'h5555;
        ROB_entries_in = {5'd0, 5'd0, 5'd0};
        tick();
        clear_inputs();
        begin
            int k;
            k = 0;
            while (rollback_valid == 2'b00 && k < 20) begin
                tick();
                k++;
            end
        end
        chk("midsquash_rollback_seen", 32'(rollback_valid != 2'b00), 32'd1);
        rst = 1'b0;
        #1;
        check_idle_outputs("midsquash_reset");
        tick();
        tick();
        rst = 1'b1;
        flush_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (flush) flush_cnt++;
        end
        chk("midsquash_no_flush", 32'(flush_cnt), 32'd0);
        chk("midsquash_entry_after", 32'(alloc_entry), 32'd0);
        chk("midsquash_ready_after", 32'(alloc_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
